// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped, one-word-per-entry instruction cache between fetch and the memory controller.
// Define ICACHE_STATS_EN to add the ic_hit_cnt / ic_miss_cnt lookup counters.
module icache_fetch #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        if_to_ic_req,
  input  logic [31:0] if_to_ic_pc,
  output logic        ic_to_if_ready,
  output logic [31:0] ic_to_if_inst,
  input  logic        mc_to_if_valid,
  output logic        ic_to_mc_ready,
  output logic [31:0] ic_to_mc_pc,
  input  logic        mc_to_if_ready,
  input  logic [31:0] mc_to_if_inst
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] ic_hit_cnt,
  output logic [31:0] ic_miss_cnt
`endif
);
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;
  localparam int ENTRIES = 1 << INDEX_WIDTH;
  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_WAIT} state_t;
  state_t state;
  logic [ENTRIES-1:0] valid;
  logic [TAG_WIDTH-1:0] tag_mem [ENTRIES];
  logic [31:0] data_mem [ENTRIES];
  logic [31:0] miss_pc;
  logic [INDEX_WIDTH-1:0] idx, miss_idx;
  logic [TAG_WIDTH-1:0] tag;
  logic hit;
  assign idx = if_to_ic_pc[INDEX_WIDTH+1:2];
  assign tag = if_to_ic_pc[31:INDEX_WIDTH+2];
  assign miss_idx = miss_pc[INDEX_WIDTH+1:2];
  assign hit = valid[idx] && tag_mem[idx] == tag;
  assign ic_to_mc_ready = state == MISS_REQ;
  assign ic_to_mc_pc = miss_pc;
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      valid <= '0;
      state <= IDLE;
      ic_to_if_ready <= 1'b0;
      ic_to_if_inst <= '0;
      miss_pc <= '0;
`ifdef ICACHE_STATS_EN
      ic_hit_cnt <= '0;
      ic_miss_cnt <= '0;
`endif
    end else if (rdy_in) begin
      if (clr_in) begin
        state <= IDLE;
        ic_to_if_ready <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            ic_to_if_ready <= 1'b0;
            // a request seen during the response pulse is the one just answered
            if (if_to_ic_req && !ic_to_if_ready) begin
              if (hit) begin
                ic_to_if_inst <= data_mem[idx];
                ic_to_if_ready <= 1'b1;
`ifdef ICACHE_STATS_EN
                ic_hit_cnt <= ic_hit_cnt + 32'd1;
`endif
              end else begin
                miss_pc <= if_to_ic_pc & ~32'd3;
                state <= MISS_REQ;
`ifdef ICACHE_STATS_EN
                ic_miss_cnt <= ic_miss_cnt + 32'd1;
`endif
              end
            end
          end
          MISS_REQ: if (mc_to_if_valid) state <= MISS_WAIT;
          MISS_WAIT: if (mc_to_if_ready) begin
            valid[miss_idx] <= 1'b1;
            tag_mem[miss_idx] <= miss_pc[31:INDEX_WIDTH+2];
            data_mem[miss_idx] <= mc_to_if_inst;
            ic_to_if_inst <= mc_to_if_inst;
            ic_to_if_ready <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped, one-word-per-entry instruction cache between the fetch unit (upstream) and the memory controller's instruction port (downstream).
- Serves instruction words to fetch on a hit with a fixed 1-cycle response.
- On a miss, issues a single word-fetch handshake to the memory controller, fills the entry, then answers fetch.
- Contents survive pipeline flushes; only reset invalidates them.

Parameters:
- INDEX_WIDTH, 8, index bits; entry count = 2^INDEX_WIDTH; index = pc[INDEX_WIDTH+1:2].
- TAG_WIDTH, 30-INDEX_WIDTH, tag = pc[31:INDEX_WIDTH+2]; derived, not overridden.

Ports:
- clk_in  in  1  clock, all state updates on rising edge
- rst_n_in  in  1  synchronous active-low reset
- rdy_in  in  1  global ready; when low, all state and outputs hold
- clr_in  in  1  pipeline flush (mispredict); synchronous, active-high
- if_to_ic_req  in  1  fetch request, level; held until response
- if_to_ic_pc  in  32  fetch address; bits[1:0] ignored
- ic_to_if_ready  out  1  one-cycle pulse: ic_to_if_inst valid
- ic_to_if_inst  out  32  instruction word
- mc_to_if_valid  in  1  memory controller idle and able to accept a fetch
- ic_to_mc_ready  out  1  miss fetch request to memory controller (combinational from state)
- ic_to_mc_pc  out  32  miss address, word-aligned (pc with [1:0]=0)
- mc_to_if_ready  in  1  one-cycle pulse: mc_to_if_inst valid
- mc_to_if_inst  in  32  fetched word

Behaviour:
- Storage: valid[2^INDEX_WIDTH], tag array, data array (32 bits each).
- Reset (rst_n_in low at edge):
  - all valid bits cleared; state=IDLE
  - ic_to_if_ready=0, ic_to_if_inst=0, miss address register=0
  - reset mid-miss abandons the miss without a fill
- rdy_in low: no state, array or output change; overrides everything except reset.
- clr_in high (rdy_in high):
  - state=IDLE, ic_to_if_ready=0
  - array contents kept
  - a miss in flight is dropped; the memory controller clears on the same clr_in
  - a late mc_to_if_ready pulse while IDLE is ignored, with no fill
- States:
  - IDLE, ic_to_mc_ready=0:
    - ic_to_if_ready defaults to 0 each cycle.
    - If if_to_ic_req, a combinational lookup runs.
    - Hit (valid && tag match): ic_to_if_inst<=data, ic_to_if_ready<=1 next cycle, stay IDLE.
    - Miss: latch pc&~3 into the miss register, go to MISS_REQ.
    - A request in the cycle ic_to_if_ready is high is not looked up; fetch must observe the pulse and may re-request from the next cycle. This gives at most one response per 2 cycles.
  - MISS_REQ, ic_to_mc_ready=1, ic_to_mc_pc=miss register:
    - If mc_to_if_valid, go to MISS_WAIT at that edge; the memory controller samples the request on the same edge.
    - Otherwise hold (the load/store unit has priority).
  - MISS_WAIT, ic_to_mc_ready=0:
    - On mc_to_if_ready, write valid=1, tag and data at the miss index (overwriting any previous entry).
    - Same edge: ic_to_if_inst<=mc_to_if_inst, ic_to_if_ready<=1, go to IDLE.
- ic_to_mc_ready is low in every state except MISS_REQ, so no duplicate fetch is issued while the controller returns to idle.
- Latency:
  - hit: response 1 cycle after request sampled
  - miss: 1 cycle (to MISS_REQ) + arbitration wait + controller latency + 0 (response registered on the fill edge)
- Fetch must hold if_to_ic_pc stable while if_to_ic_req is high. The response always corresponds to the address latched at lookup.
- Conflict: two PCs with the same index thrash; each miss replaces the entry; no error.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined: adds outputs ic_hit_cnt (out, 32) and ic_miss_cnt (out, 32).
  - Each counts IDLE lookups with rdy_in high and clr_in low, by result.
  - Both reset to 0 on reset only, not on clr_in.
  - 32-bit wrap-around at 0xFFFFFFFF -> 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold miss: after reset, req pc=0x00000000; controller returns 0x00000013 -> ic_to_mc_ready high with ic_to_mc_pc=0x0, one ic_to_if_ready pulse with inst=0x00000013, entry filled.
- Hit: re-request pc=0x00000000 -> ic_to_if_ready exactly 1 cycle later, inst=0x00000013, ic_to_mc_ready never asserted.
- Arbitration stall: miss at pc=0x100 with mc_to_if_valid low for 5 cycles -> ic_to_mc_ready held high 5 cycles. Transition to MISS_WAIT on the first valid cycle; ic_to_mc_ready low afterward.
- Conflict eviction (INDEX_WIDTH=8): fill pc=0x004 (0xAAAA0001), then pc=0x404 (0xBBBB0002), then pc=0x004 -> third access misses; response 0xAAAA0001.
- Flush mid-miss: clr_in asserted in MISS_WAIT, then a stray mc_to_if_ready with 0xDEADBEEF -> no ic_to_if_ready, entry stays invalid, next req at the same pc misses again.
- rdy_in low for 3 cycles during MISS_REQ with mc_to_if_valid high -> no state change, no transition until rdy_in returns high; with ICACHE_STATS_EN, counters unchanged during the stall.
